// File: rtl/wb_register_file.sv
// Architectural register file fed by write-back: two combinational ID read ports, a debug
// read port and a committed-write counter. Define WB_REGFILE_BYPASS_EN for write-first rs1/rs2 forwarding.
module wb_register_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   reg_write_in,
  input  logic [ADDR_WIDTH-1:0]  reg_rd_in,
  input  logic [DATA_WIDTH-1:0]  write_data_in,
  input  logic [ADDR_WIDTH-1:0]  rs1_addr,
  input  logic [ADDR_WIDTH-1:0]  rs2_addr,
  input  logic [ADDR_WIDTH-1:0]  dbg_addr,
  output logic [DATA_WIDTH-1:0]  rs1_data,
  output logic [DATA_WIDTH-1:0]  rs2_data,
  output logic [DATA_WIDTH-1:0]  dbg_data,
  output logic [COUNT_WIDTH-1:0] wb_count
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]    wr_sel;
  logic                   write_accept;
  logic [COUNT_WIDTH-1:0] wb_count_reg;
  logic [COUNT_WIDTH-1:0] wb_count_next;

  // Reset is folded in here so a write arriving with reset is neither stored nor counted.
  assign write_accept = reg_write_in && (reg_rd_in != '0) && !reset;

  // One-hot write decode; entry 0 is never selected, keeping x0 at its reset value of zero.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
      if (gi == 0) begin : g_zero
        assign wr_sel[gi] = 1'b0;
      end else begin : g_dec
        assign wr_sel[gi] = write_accept && (reg_rd_in == ADDR_WIDTH'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs_reg[i] <= '0;
      end else if (wr_sel[i]) begin
        regs_reg[i] <= write_data_in;
      end
    end
  end

  // Free-running wrap at 2**COUNT_WIDTH; no saturation by design.
  always_comb begin
    wb_count_next = wb_count_reg;
    if (write_accept) begin
      wb_count_next = wb_count_reg + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_count_reg <= '0;
    end else begin
      wb_count_reg <= wb_count_next;
    end
  end

  assign wb_count = wb_count_reg;

  logic [DATA_WIDTH-1:0] rs1_array;
  logic [DATA_WIDTH-1:0] rs2_array;

  assign rs1_array = (rs1_addr == '0) ? '0 : regs_reg[rs1_addr];
  assign rs2_array = (rs2_addr == '0) ? '0 : regs_reg[rs2_addr];

`ifdef WB_REGFILE_BYPASS_EN
  // write_accept already excludes x0, so forwarding can never make index 0 non-zero.
  logic rs1_fwd;
  logic rs2_fwd;

  assign rs1_fwd  = write_accept && (rs1_addr == reg_rd_in);
  assign rs2_fwd  = write_accept && (rs2_addr == reg_rd_in);
  assign rs1_data = rs1_fwd ? write_data_in : rs1_array;
  assign rs2_data = rs2_fwd ? write_data_in : rs2_array;
`else
  assign rs1_data = rs1_array;
  assign rs2_data = rs2_array;
`endif

  // Debug port always shows committed architectural state.
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_reg[dbg_addr];

endmodule

// File: tb/tb_wb_register_file.sv
// Randomized self-checking bench for wb_register_file against an array/counter reference model,
// with a second instance (COUNT_WIDTH=4) to observe counter wrap.
module tb_wb_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic        reg_write_in;
  logic [4:0]  reg_rd_in;
  logic [31:0] write_data_in;
  logic [4:0]  rs1_addr, rs2_addr, dbg_addr;
  logic [31:0] rs1_data, rs2_data, dbg_data, wb_count;
  logic [31:0] rs1_b, rs2_b, dbg_b;
  logic [3:0]  wb_count_b;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model_regs [32];
  int unsigned model_count;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clock = ~clock;

  wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .reg_write_in(reg_write_in), .reg_rd_in(reg_rd_in),
    .write_data_in(write_data_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .dbg_addr(dbg_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .dbg_data(dbg_data), .wb_count(wb_count)
  );

  wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .COUNT_WIDTH(4)) dut_c4 (
    .clock(clock), .reset(reset), .reg_write_in(reg_write_in), .reg_rd_in(reg_rd_in),
    .write_data_in(write_data_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .dbg_addr(dbg_addr), .rs1_data(rs1_b), .rs2_data(rs2_b),
    .dbg_data(dbg_b), .wb_count(wb_count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit fwd_ok,
                                           input bit rst, input bit we,
                                           input logic [4:0] rd, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (fwd_ok && BYPASS && we && !rst && rd != 5'd0 && a == rd) return wd;
    return model_regs[a];
  endfunction

  // One clock cycle: drive, check combinational outputs mid-cycle, then commit to the model.
  task automatic step(input bit rst, input bit we, input logic [4:0] rd, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    logic [31:0] e1, e2, ed;
    reset = rst; reg_write_in = we; reg_rd_in = rd; write_data_in = wd;
    rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
    @(negedge clock);
    e1 = exp_read(a1, 1'b1, rst, we, rd, wd);
    e2 = exp_read(a2, 1'b1, rst, we, rd, wd);
    ed = exp_read(ad, 1'b0, rst, we, rd, wd);
    check("rs1_data", rs1_data, e1);
    check("rs2_data", rs2_data, e2);
    check("dbg_data", dbg_data, ed);
    check("wb_count", wb_count, model_count);
    check("wb_count_w4", {28'h0, wb_count_b}, model_count % 16);
    $display("cyc rst=%0d we=%0d rd=%0d wd=%h a1=%0d a2=%0d ad=%0d -> rs1=%h rs2=%h dbg=%h cnt=%0d cnt4=%0d",
             rst, we, rd, wd, a1, a2, ad, rs1_data, rs2_data, dbg_data, wb_count, wb_count_b);
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
      model_count = 0;
    end else if (we && rd != 5'd0) begin
      model_regs[rd] = wd;
      model_count++;
    end
    #1;
  endtask

  initial begin
    logic [4:0]  r_rd, r_a1, r_a2, r_ad;
    logic [31:0] r_wd;
    bit          r_we, r_rst;

    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_count = 0;
    reset = 1'b1; reg_write_in = 1'b0; reg_rd_in = '0; write_data_in = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    @(posedge clock); #1;
    step(1, 0, 0, 0, 0, 0, 0);

    // Every index reads zero after reset.
    for (int i = 0; i < 32; i++)
      step(0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));

    // x5 write then read.
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 5, 5, 5);

    // x0 writes are ignored and not counted.
    step(0, 1, 0, 32'h12345678, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Same-cycle write/read of x7.
    step(0, 1, 7, 32'h11111111, 0, 0, 0);
    step(0, 1, 7, 32'hA5A5A5A5, 7, 7, 7);
    step(0, 0, 0, 0, 7, 7, 7);

    // Reset beats a concurrent write.
    step(1, 1, 3, 32'hFFFFFFFF, 3, 3, 3);
    step(0, 0, 0, 0, 3, 3, 3);

    // 17 accepted writes: the 4-bit counter wraps 15 -> 0 -> 1.
    for (int i = 1; i <= 17; i++) begin
      r_rd = (i <= 15) ? 5'(i) : 5'(i - 15);
      step(0, 1, r_rd, $urandom, r_rd, 5'(i), 5'(i - 1));
    end
    step(0, 0, 0, 0, 1, 2, 15);

    // Randomized traffic, biased toward read/write address collisions.
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 49) == 0);
      r_we  = ($urandom_range(0, 3) != 0);
      r_rd  = 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      r_a1  = ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_a2  = ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_ad  = ($urandom_range(0, 2) == 0) ? r_rd : 5'($urandom_range(0, 31));
      step(r_rst, r_we, r_rd, r_wd, r_a1, r_a2, r_ad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Architectural register file that receives the write-back stage outputs: write data, destination register and write enable.
- Serves the ID stage with two combinational read ports and adds one debug read port.
- Holds a committed-write counter for performance and debug use.
- Sits between the WB stage (write side) and the ID stage / hazard logic (read side).

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH
- COUNT_WIDTH, 32, width of the committed-write counter

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- reg_write_in  input  1  write enable from the WB stage
- reg_rd_in  input  ADDR_WIDTH  destination register index from the WB stage
- write_data_in  input  DATA_WIDTH  write-back data (mux result of the WB stage)
- rs1_addr  input  ADDR_WIDTH  read port 1 index (ID stage)
- rs2_addr  input  ADDR_WIDTH  read port 2 index (ID stage)
- dbg_addr  input  ADDR_WIDTH  debug read port index
- rs1_data  output  DATA_WIDTH  read port 1 data
- rs2_data  output  DATA_WIDTH  read port 2 data
- dbg_data  output  DATA_WIDTH  debug read data (never bypassed)
- wb_count  output  COUNT_WIDTH  number of committed writes since reset

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; reset asserted at a rising edge clears all registers and wb_count to 0.
- Reset priority: reset beats any write presented in the same cycle; that write is dropped and not counted.
- Outputs after reset: rs1_data, rs2_data and dbg_data read 0 for every address. wb_count = 0.
- Write acceptance: a write is accepted at a rising edge when reg_write_in=1 AND reg_rd_in!=0 AND reset=0. The register is updated with write_data_in, visible after the edge (latency 1 for the array).
- Register 0: hardwired to zero.
  - Writes with reg_rd_in=0 are ignored and not counted.
  - Reads of index 0 on any port return 0, including under bypass.
- Read ports: rs1/rs2/dbg reads are purely combinational from the array, with no clock latency.
  - Without bypass, a read of the register being written in the same cycle returns the old value.
- Counter: wb_count increments by 1 on each accepted write.
  - Wraps from 2**COUNT_WIDTH-1 to 0 with no saturation and no flag.
  - Holds when no write is accepted.
- Simultaneous events:
  - rs1_addr = rs2_addr = reg_rd_in is legal; both ports get identical data.
  - A write and a read of a different register do not interact.
- Reset mid-operation: pending WB inputs in the reset cycle have no effect. Operation resumes normally the cycle after reset deasserts.
- No X propagation: all registers have defined reset values. Out-of-range indices are impossible by width.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN
- Defined: write-first internal forwarding on rs1/rs2.
  - If reg_write_in=1, reg_rd_in!=0, reset=0 and rsN_addr==reg_rd_in, then rsN_data = write_data_in in the same cycle, combinationally.
  - This removes the WB→ID hazard for the forwarding unit.
  - dbg_data is never bypassed.
- Undefined: no bypass logic is generated; reads return array contents only. The hazard/forwarding logic covers the one-cycle WB→ID window.

Test Plan:
- Reset then read all 32 indices on rs1/rs2/dbg -> every read = 0x00000000; wb_count=0.
- Write x5=0xDEADBEEF (reg_write_in=1, reg_rd_in=5), next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF; wb_count=1.
- Write x0=0x12345678, then read rs1_addr=0 and rs2_addr=0 -> both 0; wb_count unchanged.
- Same-cycle write x7=0xA5A5A5A5 with rs1_addr=rs2_addr=7, old x7=0x11111111:
  - with the macro: both ports read 0xA5A5A5A5 in that cycle;
  - without the macro: both read 0x11111111, then 0xA5A5A5A5 next cycle;
  - dbg_addr=7 reads 0x11111111 in that cycle in both builds.
- reset=1 together with a write of x3=0xFFFFFFFF -> x3 reads 0 afterwards and wb_count=0.
- COUNT_WIDTH=4, 17 accepted writes (the spec does not restrict rd choice; use rd=1..15 then 1, 2) -> wb_count wraps 15→0 and reads 1.
